sega_pad_responder: RTL and testbench



---
 rtl/sega_pad_pkg.sv | 64 ++++++
 rtl/sel_edge_sync.sv | 30 +++
 rtl/sega_pad_responder.sv | 72 +++++++
 tb/tb_sega_pad_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sega_pad_pkg.sv
// Shared constants and the DB9 output map for the Mega Drive pad responder.
package sega_pad_pkg;

  // btn_i bit positions, MXYZ SACB RLDU
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_B = 4;
  localparam int BTN_C = 5;
  localparam int BTN_A = 6;
  localparam int BTN_S = 7;
  localparam int BTN_Z = 8;
  localparam int BTN_Y = 9;
  localparam int BTN_X = 10;
  localparam int BTN_M = 11;

  // pad_o bit positions: p4, p3, p2, p1, p6, p9
  localparam int PAD_R  = 0;
  localparam int PAD_L  = 1;
  localparam int PAD_D  = 2;
  localparam int PAD_U  = 3;
  localparam int PAD_P6 = 4;
  localparam int PAD_P9 = 5;

  localparam logic [2:0] CNT_IDLE = 3'd0;
  localparam logic [2:0] CNT_ID   = 3'd5;
  localparam logic [2:0] CNT_XYZM = 3'd6;
  localparam logic [2:0] CNT_HI   = 3'd7;

  localparam logic [5:0] PAD_IDLE = 6'b111111;

  // Negative-logic pin image for a given select level, edge count and button word.
  function automatic logic [5:0] pad_map(input logic sel, input logic [2:0] cnt,
                                         input logic [11:0] btn);
    logic [5:0] pad;
    pad = PAD_IDLE;
    if (sel) begin
      pad[PAD_P9] = ~btn[BTN_C];
      pad[PAD_P6] = ~btn[BTN_B];
      if (cnt == CNT_XYZM) begin
        pad[PAD_U] = ~btn[BTN_Z];
        pad[PAD_D] = ~btn[BTN_Y];
        pad[PAD_L] = ~btn[BTN_X];
        pad[PAD_R] = ~btn[BTN_M];
      end else begin
        pad[PAD_U] = ~btn[BTN_U];
        pad[PAD_D] = ~btn[BTN_D];
        pad[PAD_L] = ~btn[BTN_L];
        pad[PAD_R] = ~btn[BTN_R];
      end
    end else begin
      pad[PAD_P9] = ~btn[BTN_S];
      pad[PAD_P6] = ~btn[BTN_A];
      case (cnt)
        CNT_ID:  pad[PAD_U:PAD_R] = 4'b0000;
        CNT_HI:  pad[PAD_U:PAD_R] = 4'b1111;
        default: pad[PAD_U:PAD_R] = {~btn[BTN_U], ~btn[BTN_D], 2'b00};
      endcase
    end
    return pad;
  endfunction

endpackage

// File: rtl/sel_edge_sync.sv
// Multi-stage synchronizer for the DB9 select line plus a single-cycle edge pulse.
module sel_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic sel_i,
  output logic sel_s,
  output logic sel_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sel_d;

  // Stages preset high so an idle host (select high) produces no edge after reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= '1;
      sel_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous one's old value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], sel_i};
      sel_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sel_s    = sync_q[SYNC_STAGES-1];
  assign sel_edge = sel_s ^ sel_d;

endmodule

// File: rtl/sega_pad_responder.sv
// DB9 Mega Drive 3/6-button pad emulation driven by the host select line.
// Optional macro SEGA_PAD_FORCE3_EN adds force_3btn_i to restrict the pad to 3-button mode.
module sega_pad_responder #(
  parameter int TIMEOUT_CYCLES = 85909,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        sel_i,
  input  logic [11:0] btn_i,
`ifdef SEGA_PAD_FORCE3_EN
  input  logic        force_3btn_i,
`endif
  output logic [5:0]  pad_o,
  output logic [2:0]  phase_o
);

  import sega_pad_pkg::*;

  localparam int              TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic          sel_s;
  logic          sel_edge;
  logic          wrap3;
  logic [2:0]    cnt;
  logic [2:0]    cnt_nxt;
  logic [TW-1:0] timer;

  sel_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .sel_i    (sel_i),
    .sel_s    (sel_s),
    .sel_edge (sel_edge)
  );

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational signal unassigned (no latch).
    wrap3   = 1'b0;
    cnt_nxt = cnt;
`ifdef SEGA_PAD_FORCE3_EN
    wrap3   = force_3btn_i;
`endif
    // An edge always beats a coincident timeout.
    if (sel_edge) begin
      cnt_nxt = (wrap3 && cnt == 3'd3) ? CNT_IDLE : cnt + 3'd1;
    end else if (timer == TIMER_MAX) begin
      cnt_nxt = CNT_IDLE;
    end
  end

  // Output is built from the next count so pad_o and phase_o change on the same clock.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt   <= CNT_IDLE;
      timer <= '0;
      pad_o <= PAD_IDLE;
    end else begin
      cnt   <= cnt_nxt;
      pad_o <= pad_map(sel_s, cnt_nxt, btn_i);
      if (sel_edge) begin
        timer <= '0;
      end else if (timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign phase_o = cnt;

endmodule

// File: tb/tb_sega_pad_responder.sv
// Scoreboard bench for sega_pad_responder; stimulus queues expectations, a negedge monitor checks them.
module tb_sega_pad_responder;

  localparam int TO = 100;
  localparam int SS = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        sel_i;
  logic [11:0] btn_i;
  logic [5:0]  pad_o;
  logic [2:0]  phase_o;
`ifdef SEGA_PAD_FORCE3_EN
  logic        force_3btn_i;
`endif

  sega_pad_responder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SS)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .sel_i        (sel_i),
    .btn_i        (btn_i),
`ifdef SEGA_PAD_FORCE3_EN
    .force_3btn_i (force_3btn_i),
`endif
    .pad_o        (pad_o),
    .phase_o      (phase_o)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [5:0] pad;
    logic [2:0] phase;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_out(input int dly, input logic [5:0] pad, input logic [2:0] ph,
                            input string tag);
    exp_t e;
    e.due   = cyc + dly;
    e.pad   = pad;
    e.phase = ph;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Monitor: compares every expectation whose cycle has arrived.
  always @(negedge clk_sys) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due != cyc) begin
        check({e.tag, "_late"}, cyc, e.due);
      end else begin
        check({e.tag, "_pad"}, {26'd0, pad_o}, {26'd0, e.pad});
        check({e.tag, "_phase"}, {29'd0, phase_o}, {29'd0, e.phase});
      end
    end
  end

  // Hand-computed 6-button sequence for btn_i=12'hF00, edges 1..8.
  logic [5:0] six_pad [8] = '{6'b111100, 6'b111111, 6'b111100, 6'b111111,
                              6'b110000, 6'b110000, 6'b111111, 6'b111111};
  logic [2:0] six_ph  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  initial begin
    reset = 1'b1;
    sel_i = 1'b1;
    btn_i = 12'hFFF;
`ifdef SEGA_PAD_FORCE3_EN
    force_3btn_i = 1'b0;
`endif
    tick(1);
    for (int i = 0; i < 4; i++) expect_out(i, 6'b111111, 3'd0, "reset_hold");
    tick(4);

    // Idle, select high, U and B pressed.
    reset = 1'b0;
    btn_i = 12'h011;
    expect_out(1, 6'b100111, 3'd0, "idle_btn_lat");
    expect_out(3, 6'b100111, 3'd0, "idle_ub");
    tick(5);

    // U, A, S pressed; one button-latency check, then a falling edge.
    btn_i = 12'h0C1;
    expect_out(1, 6'b110111, 3'd0, "uas_high");
    tick(3);
    sel_i = 1'b0;
    expect_out(2, 6'b110111, 3'd0, "fall_before");
    expect_out(3, 6'b000100, 3'd1, "fall_edge1");
    tick(8);
    sel_i = 1'b1;
    expect_out(3, 6'b110111, 3'd2, "rise_edge2");
    tick(6);

    // Reset mid-sequence.
    reset = 1'b1;
    expect_out(1, 6'b111111, 3'd0, "midreset1");
    expect_out(2, 6'b111111, 3'd0, "midreset2");
    tick(2);
    reset = 1'b0;
    btn_i = 12'hF00;
    expect_out(1, 6'b111111, 3'd0, "post_reset");
    tick(5);

    // Four full select pulses, 10 clocks per level.
    for (int i = 0; i < 8; i++) begin
      sel_i = (i % 2 == 1);
      expect_out(3, six_pad[i], six_ph[i], $sformatf("six_e%0d", i + 1));
      tick(10);
    end

    // Timeout with select held high.
    btn_i = 12'h000;
    sel_i = 1'b0;
    expect_out(3, 6'b111100, 3'd1, "to_e1");
    tick(10);
    sel_i = 1'b1;
    expect_out(3,   6'b111111, 3'd2, "to_e2");
    expect_out(102, 6'b111111, 3'd2, "to_before");
    expect_out(103, 6'b111111, 3'd0, "to_expired");
    tick(150);

    // Next falling edge is edge 1; then a timeout while select is low.
    sel_i = 1'b0;
    expect_out(3,   6'b111100, 3'd1, "to_restart");
    expect_out(102, 6'b111100, 3'd1, "tolow_before");
    expect_out(103, 6'b111100, 3'd0, "tolow_expired");
    tick(150);

    // Edge landing on the timeout cycle: the edge wins.
    sel_i = 1'b1;
    expect_out(3,   6'b111111, 3'd1, "coin_e1");
    expect_out(102, 6'b111111, 3'd1, "coin_before");
    tick(100);
    sel_i = 1'b0;
    expect_out(3, 6'b111100, 3'd2, "coin_edge_wins");
    tick(10);

`ifdef SEGA_PAD_FORCE3_EN
    reset = 1'b1;
    sel_i = 1'b1;
    expect_out(1, 6'b111111, 3'd0, "f3_reset");
    tick(3);
    reset = 1'b0;
    force_3btn_i = 1'b1;
    expect_out(1, 6'b111111, 3'd0, "f3_idle");
    tick(5);
    for (int i = 0; i < 8; i++) begin
      sel_i = (i % 2 == 1);
      expect_out(3, (i % 2 == 1) ? 6'b111111 : 6'b111100, 3'((i + 1) % 4),
                 $sformatf("f3_e%0d", i + 1));
      tick(10);
    end
`endif

    for (int k = 0; k < 300 && sb.size() > 0; k++) @(posedge clk_sys);
    @(negedge clk_sys);
    #1;
    if (sb.size() > 0) check("scoreboard_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
